// File: rtl/oq_regs_pkg.sv
// Shared definitions for the output-queue register counter engine.
package oq_regs_pkg;

  localparam int unsigned DEF_REG_WIDTH         = 32;
  localparam int unsigned DEF_NUM_OUTPUT_QUEUES = 8;
  localparam int unsigned DEF_DELTA_WIDTH       = 16;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Ceiling log2, never below 1 so a single-queue build still has an address bit.
  function automatic int unsigned log2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << r) < 64'(n)) r = r + 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/oq_regs_cntr_update_if.sv
// Request, RAM and result bus of the counter update engine.
interface oq_regs_cntr_update_if
  import oq_regs_pkg::*;
#(
  parameter int unsigned REG_WIDTH   = DEF_REG_WIDTH,
  parameter int unsigned ADDR_WIDTH  = log2(DEF_NUM_OUTPUT_QUEUES),
  parameter int unsigned DELTA_WIDTH = DEF_DELTA_WIDTH
);

  logic                   req_valid;
  logic                   req_ready;
  logic [ADDR_WIDTH-1:0]  req_queue;
  logic [DELTA_WIDTH-1:0] req_delta;

  logic [ADDR_WIDTH-1:0]  ram_addr_a;
  logic                   ram_we_a;
  logic [REG_WIDTH-1:0]   ram_din_a;
  logic [REG_WIDTH-1:0]   ram_dout_a;
  logic [ADDR_WIDTH-1:0]  ram_addr_b;
  logic                   ram_we_b;
  logic [REG_WIDTH-1:0]   ram_din_b;

  logic                   init_done;
  logic                   upd_valid;
  logic [ADDR_WIDTH-1:0]  upd_queue;
  logic [REG_WIDTH-1:0]   upd_value;
  logic                   ovf_pulse;
  logic                   unf_pulse;

  // Datapath / RAM side.
  modport master (
    output req_valid, req_queue, req_delta, ram_dout_a,
    input  req_ready, ram_addr_a, ram_we_a, ram_din_a,
    input  ram_addr_b, ram_we_b, ram_din_b,
    input  init_done, upd_valid, upd_queue, upd_value, ovf_pulse, unf_pulse
  );

  // Engine side.
  modport slave (
    input  req_valid, req_queue, req_delta, ram_dout_a,
    output req_ready, ram_addr_a, ram_we_a, ram_din_a,
    output ram_addr_b, ram_we_b, ram_din_b,
    output init_done, upd_valid, upd_queue, upd_value, ovf_pulse, unf_pulse
  );

endinterface

// File: rtl/oq_regs_cntr_alu.sv
// Sign-extend, add and range-check one counter update.
// OQ_CNTR_SAT_EN selects clamping instead of modulo wrap on out-of-range results.
module oq_regs_cntr_alu
  import oq_regs_pkg::*;
#(
  parameter int unsigned REG_WIDTH   = DEF_REG_WIDTH,
  parameter int unsigned DELTA_WIDTH = DEF_DELTA_WIDTH
) (
  input  logic [REG_WIDTH-1:0]   base,
  input  logic [DELTA_WIDTH-1:0] delta,
  output logic [REG_WIDTH-1:0]   result_c,
  output logic                   ovf_c,
  output logic                   unf_c
);

  localparam int unsigned SUM_W = REG_WIDTH + 1;

  logic [SUM_W-1:0] delta_ext;
  logic [SUM_W-1:0] sum;
  logic             neg;

  // Top sum bit is a carry for positive deltas and a borrow for negative ones.
  always_comb begin
    delta_ext = SUM_W'($signed(delta));
    sum       = {1'b0, base} + delta_ext;
    neg       = delta[DELTA_WIDTH-1];
    ovf_c     = ~neg & sum[REG_WIDTH];
    unf_c     =  neg & sum[REG_WIDTH];
`ifdef OQ_CNTR_SAT_EN
    if (ovf_c)      result_c = '1;
    else if (unf_c) result_c = '0;
    else            result_c = sum[REG_WIDTH-1:0];
`else
    result_c = sum[REG_WIDTH-1:0];
`endif
  end

endmodule

// File: rtl/oq_regs_cntr_update.sv
// Read-modify-write engine for per-queue counters with zero sweep after reset.
// Build option OQ_CNTR_SAT_EN (handled in oq_regs_cntr_alu) clamps instead of wrapping.
module oq_regs_cntr_update
  import oq_regs_pkg::*;
#(
  parameter int unsigned REG_WIDTH           = DEF_REG_WIDTH,
  parameter int unsigned NUM_OUTPUT_QUEUES   = DEF_NUM_OUTPUT_QUEUES,
  parameter int unsigned REG_FILE_ADDR_WIDTH = log2(NUM_OUTPUT_QUEUES),
  parameter int unsigned DELTA_WIDTH         = DEF_DELTA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  oq_regs_cntr_update_if.slave  bus
);

  localparam int unsigned AW = REG_FILE_ADDR_WIDTH;
  localparam logic [AW-1:0] LAST_Q = AW'(NUM_OUTPUT_QUEUES - 1);

  state_t                 state;
  logic [AW-1:0]          cnt;

  logic                   s1_valid;
  logic [AW-1:0]          s1_queue;
  logic [DELTA_WIDTH-1:0] s1_delta;

  logic                   w_valid;
  logic [AW-1:0]          w_queue;
  logic [REG_WIDTH-1:0]   w_value;

  logic                   run;
  logic                   accept;
  logic                   bypass;
  logic [REG_WIDTH-1:0]   base;
  logic [REG_WIDTH-1:0]   alu_result;
  logic                   alu_ovf;
  logic                   alu_unf;

  assign run    = (state == ST_RUN);
  assign accept = bus.req_valid & run;
  // Only the write committed at the edge that loaded S1 can be missing from the read.
  assign bypass = w_valid & (w_queue == s1_queue);
  assign base   = bypass ? w_value : bus.ram_dout_a;

  oq_regs_cntr_alu #(
    .REG_WIDTH   (REG_WIDTH),
    .DELTA_WIDTH (DELTA_WIDTH)
  ) u_alu (
    .base     (base),
    .delta    (s1_delta),
    .result_c (alu_result),
    .ovf_c    (alu_ovf),
    .unf_c    (alu_unf)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_INIT;
      cnt      <= '0;
      s1_valid <= 1'b0;
      s1_queue <= '0;
      s1_delta <= '0;
      w_valid  <= 1'b0;
      w_queue  <= '0;
      w_value  <= '0;
    end else begin
      case (state)
        ST_INIT: begin
          cnt <= cnt + AW'(1);
          if (cnt == LAST_Q) state <= ST_RUN;
        end
        ST_RUN:  state <= ST_RUN;
        default: state <= ST_INIT;
      endcase

      s1_valid <= accept;
      if (accept) begin
        s1_queue <= bus.req_queue;
        s1_delta <= bus.req_delta;
      end

      w_valid <= s1_valid;
      if (s1_valid) begin
        w_queue <= s1_queue;
        w_value <= alu_result;
      end
    end
  end

  // Port A reads for the accepting request; port B either sweeps or commits S1.
  always_comb begin
    bus.req_ready  = run;
    bus.init_done  = run;
    bus.ram_addr_a = run ? bus.req_queue : '0;
    bus.ram_we_a   = 1'b0;
    bus.ram_din_a  = '0;

    bus.ram_we_b   = 1'b0;
    bus.ram_addr_b = '0;
    bus.ram_din_b  = '0;
    if (!run && !reset) begin
      bus.ram_we_b   = 1'b1;
      bus.ram_addr_b = cnt;
    end else if (s1_valid) begin
      bus.ram_we_b   = 1'b1;
      bus.ram_addr_b = s1_queue;
      bus.ram_din_b  = alu_result;
    end

    bus.upd_valid = s1_valid;
    bus.upd_queue = s1_valid ? s1_queue : '0;
    bus.upd_value = s1_valid ? alu_result : '0;
    bus.ovf_pulse = s1_valid & alu_ovf;
    bus.unf_pulse = s1_valid & alu_unf;
  end

endmodule

// File: tb/tb_oq_regs_cntr_update.sv
// Directed bench for oq_regs_cntr_update with a RAM model and a counter reference model.
module tb_oq_regs_cntr_update;
  import oq_regs_pkg::*;

  localparam int unsigned RW = 32;
  localparam int unsigned NQ = 8;
  localparam int unsigned AW = log2(NQ);
  localparam int unsigned DW = 16;

`ifdef OQ_CNTR_SAT_EN
  localparam logic [RW-1:0] EXP_OVF = 32'hFFFF_FFFF;
  localparam logic [RW-1:0] EXP_UNF = 32'h0000_0000;
`else
  localparam logic [RW-1:0] EXP_OVF = 32'h0000_0001;
  localparam logic [RW-1:0] EXP_UNF = 32'hFFFF_FFFD;
`endif

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  oq_regs_cntr_update_if #(.REG_WIDTH(RW), .ADDR_WIDTH(AW), .DELTA_WIDTH(DW)) bus ();

  oq_regs_cntr_update #(
    .REG_WIDTH(RW), .NUM_OUTPUT_QUEUES(NQ), .REG_FILE_ADDR_WIDTH(AW), .DELTA_WIDTH(DW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // RAM: sync read, sync write, read-before-write; poke lets the bench preload entries.
  logic [RW-1:0] mem [NQ];
  logic          poke_en = 1'b0;
  logic [AW-1:0] poke_addr = '0;
  logic [RW-1:0] poke_data = '0;

  always @(posedge clk) begin
    bus.ram_dout_a <= mem[bus.ram_addr_a];
    if (bus.ram_we_b) mem[bus.ram_addr_b] <= bus.ram_din_b;
    if (poke_en)      mem[poke_addr]      <= poke_data;
  end

  typedef struct {
    int            due;
    logic [AW-1:0] q;
    logic [RW-1:0] v;
    logic          ovf;
    logic          unf;
  } exp_t;

  logic [RW-1:0] model_cnt [NQ];
  exp_t          expq [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Counter semantics in plain integer arithmetic.
  task automatic model_apply(input logic [AW-1:0] q, input logic [DW-1:0] d,
                             output logic [RW-1:0] v, output logic o, output logic u);
    longint s;
    longint maxv;
    maxv = (longint'(1) << RW) - 1;
    s = longint'(model_cnt[q]) + longint'($signed(d));
    o = 1'b0;
    u = 1'b0;
    if (s > maxv) begin
      o = 1'b1;
`ifdef OQ_CNTR_SAT_EN
      s = maxv;
`else
      s = s - (maxv + 1);
`endif
    end else if (s < 0) begin
      u = 1'b1;
`ifdef OQ_CNTR_SAT_EN
      s = 0;
`else
      s = s + (maxv + 1);
`endif
    end
    v = RW'(s);
    model_cnt[q] = v;
  endtask

  task automatic model_clear();
    for (int i = 0; i < NQ; i++) model_cnt[i] = '0;
    expq.delete();
  endtask

  task automatic send(input logic [AW-1:0] q, input logic [DW-1:0] d,
                      input logic [RW-1:0] lit_v, input logic lit_o, input logic lit_u);
    exp_t e;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b1;
    bus.req_queue = q;
    bus.req_delta = d;
    model_apply(q, d, e.v, e.ovf, e.unf);
    e.q   = q;
    e.due = cyc + 1;
    expq.push_back(e);
    chk("model_value", 64'(e.v), 64'(lit_v));
    chk("model_ovf", 64'(e.ovf), 64'(lit_o));
    chk("model_unf", 64'(e.unf), 64'(lit_u));
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_req_ready"},  64'(bus.req_ready), 0);
    chk({tag, "_ram_addr_a"}, 64'(bus.ram_addr_a), 0);
    chk({tag, "_ram_we_a"},   64'(bus.ram_we_a), 0);
    chk({tag, "_ram_din_a"},  64'(bus.ram_din_a), 0);
    chk({tag, "_ram_addr_b"}, 64'(bus.ram_addr_b), 0);
    chk({tag, "_ram_we_b"},   64'(bus.ram_we_b), 0);
    chk({tag, "_ram_din_b"},  64'(bus.ram_din_b), 0);
    chk({tag, "_init_done"},  64'(bus.init_done), 0);
    chk({tag, "_upd_valid"},  64'(bus.upd_valid), 0);
    chk({tag, "_upd_queue"},  64'(bus.upd_queue), 0);
    chk({tag, "_upd_value"},  64'(bus.upd_value), 0);
    chk({tag, "_ovf_pulse"},  64'(bus.ovf_pulse), 0);
    chk({tag, "_unf_pulse"},  64'(bus.unf_pulse), 0);
  endtask

  // Called right after reset release: eight sweep writes, then init_done.
  task automatic check_sweep();
    for (int i = 0; i < NQ; i++) begin
      @(negedge clk);
      chk("sweep_we_b", 64'(bus.ram_we_b), 1);
      chk("sweep_addr_b", 64'(bus.ram_addr_b), 64'(i));
      chk("sweep_din_b", 64'(bus.ram_din_b), 0);
      chk("sweep_req_ready", 64'(bus.req_ready), 0);
      chk("sweep_init_done", 64'(bus.init_done), 0);
      chk("sweep_upd_valid", 64'(bus.upd_valid), 0);
    end
    @(negedge clk);
    chk("run_init_done", 64'(bus.init_done), 1);
    chk("run_req_ready", 64'(bus.req_ready), 1);
    chk("run_we_b", 64'(bus.ram_we_b), 0);
  endtask

  // Per-cycle compare of the write/result port against the model's expectations.
  always @(negedge clk) begin
    if (!reset && bus.init_done) begin
      exp_t e;
      logic exp_now;
      while (expq.size() > 0 && expq[0].due < cyc) begin
        e = expq.pop_front();
        chk("result_missed", 1, 0);
      end
      exp_now = (expq.size() > 0) && (expq[0].due == cyc);
      chk("upd_valid", 64'(bus.upd_valid), 64'(exp_now));
      chk("req_ready", 64'(bus.req_ready), 1);
      if (exp_now) begin
        e = expq.pop_front();
        chk("upd_queue", 64'(bus.upd_queue), 64'(e.q));
        chk("upd_value", 64'(bus.upd_value), 64'(e.v));
        chk("ovf_pulse", 64'(bus.ovf_pulse), 64'(e.ovf));
        chk("unf_pulse", 64'(bus.unf_pulse), 64'(e.unf));
        chk("ram_we_b", 64'(bus.ram_we_b), 1);
        chk("ram_addr_b", 64'(bus.ram_addr_b), 64'(e.q));
        chk("ram_din_b", 64'(bus.ram_din_b), 64'(e.v));
      end else begin
        chk("idle_we_b", 64'(bus.ram_we_b), 0);
        chk("idle_ovf", 64'(bus.ovf_pulse), 0);
        chk("idle_unf", 64'(bus.unf_pulse), 0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    reset         = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_queue = '0;
    bus.req_delta = '0;
    model_clear();

    // Fill RAM with garbage so the sweep is observable.
    for (int i = 0; i < NQ; i++) begin
      @(negedge clk);
      poke_en   = 1'b1;
      poke_addr = AW'(i);
      poke_data = 32'hA5A5_0000 + 32'(i);
    end
    @(negedge clk);
    poke_en = 1'b0;
    bus.req_queue = AW'(5);
    check_all_zero("reset");

    @(posedge clk);
    #1;
    reset = 1'b0;
    model_clear();
    check_sweep();
    for (int i = 0; i < NQ; i++) chk("ram_swept", 64'(mem[i]), 0);

    // Sparse updates to one queue.
    send(3, 16'd5, 32'd5, 0, 0);
    idle(1);
    send(3, 16'd7, 32'd12, 0, 0);
    idle(2);
    chk("ram_q3", 64'(mem[3]), 64'd12);

    // Back-to-back same queue through the bypass.
    send(2, 16'd1, 32'd1, 0, 0);
    send(2, 16'd1, 32'd2, 0, 0);
    send(2, 16'd1, 32'd3, 0, 0);
    send(2, 16'd1, 32'd4, 0, 0);
    // Interleaved queues.
    send(6, 16'd1, 32'd1, 0, 0);
    send(5, 16'd1, 32'd1, 0, 0);
    send(6, 16'd1, 32'd2, 0, 0);
    send(5, 16'd1, 32'd2, 0, 0);
    idle(2);
    chk("ram_q2", 64'(mem[2]), 64'd4);

    // Preload q0 near the top, then overflow it.
    @(negedge clk);
    poke_en   = 1'b1;
    poke_addr = AW'(0);
    poke_data = 32'hFFFF_FFFE;
    model_cnt[0] = 32'hFFFF_FFFE;
    @(negedge clk);
    poke_en = 1'b0;
    send(0, 16'd3, EXP_OVF, 1, 0);

    // Underflow via bypass, then in-range negative and largest positive delta.
    send(1, 16'd2, 32'd2, 0, 0);
    send(1, 16'hFFFB, EXP_UNF, 0, 1);
    send(2, 16'hFFFF, 32'd3, 0, 0);
    send(7, 16'h7FFF, 32'd32767, 0, 0);
    idle(3);
    chk("ram_q0", 64'(mem[0]), 64'(EXP_OVF));
    chk("ram_q1", 64'(mem[1]), 64'(EXP_UNF));

    // Reset while S1 holds an accepted request: the write must be dropped.
    @(posedge clk);
    #1;
    bus.req_valid = 1'b1;
    bus.req_queue = AW'(3);
    bus.req_delta = 16'd9;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    check_all_zero("midreset");
    @(posedge clk);
    #1;
    chk("ram_q3_kept", 64'(mem[3]), 64'd12);
    reset = 1'b0;
    model_clear();
    check_sweep();

    send(3, 16'd1, 32'd1, 0, 0);
    idle(3);
    chk("expect_queue_empty", 64'(expq.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
